mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single unified memory port between instruction fetch (IF) and load/store (LS).
//   LS requests carry the decoder's mem_write/mem_width. One transaction is outstanding at a time.
//   LS has priority, with a starvation guard for IF. Misaligned LS accesses are rejected.
// PARAMETERS
//   ADDR_W        32  address width
//   DATA_W        32  data width
//   STARVE_LIMIT  4   consecutive LS grants (while IF pending) before IF is forced; >=1
// PORTS
//   clk            in   1       single clock, rising edge
//   reset          in   1       synchronous, active-high
//   if_req_valid   in   1       fetch request
//   if_req_ready   out  1       fetch request accepted this cycle
//   if_addr        in   ADDR_W  fetch address (word aligned)
//   if_rsp_valid   out  1       fetch data valid (1-cycle pulse)
//   if_rdata       out  DATA_W  fetch data
//   ls_req_valid   in   1       load/store request
//   ls_req_ready   out  1       LS request accepted this cycle
//   ls_addr        in   ADDR_W  LS address
//   ls_we          in   1       1=store, 0=load
//   ls_width       in   3       funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ls_wdata       in   DATA_W  store data
//   ls_rsp_valid   out  1       LS completion (1-cycle pulse; loads and stores)
//   ls_rsp_err     out  1       qualifies ls_rsp_valid: misaligned, no memory access
//   ls_rdata       out  DATA_W  load data; 0 on store or error
//   mem_req_valid  out  1       memory request
//   mem_req_ready  in   1       memory accepts request
//   mem_addr       out  ADDR_W  registered address
//   mem_we         out  1       registered write enable (0 for IF)
//   mem_width      out  3       registered width (010 for IF)
//   mem_wdata      out  DATA_W  registered store data
//   mem_rsp_valid  in   1       memory response/ack (reads and writes)
//   mem_rdata      in   DATA_W  memory read data
//   err_spurious   out  1       sticky: mem_rsp_valid seen outside WAIT
// BEHAVIOUR
//   Reset: state=IDLE; streak=0. All outputs 0, except mem_width=010. err_spurious cleared.
//     Reset mid-transaction drops it silently; the memory shares the same reset.
//   FSM: IDLE -> REQ -> WAIT -> IDLE; IDLE -> MISAL -> IDLE.
//   IDLE grant:
//     - Any valid: grant one requester. Pulse its *_req_ready for the cycle. Latch addr/we/width/wdata and owner.
//     - Unaligned LS (H: addr[0]!=0; W: addr[1:0]!=0; B never): go MISAL. Otherwise go REQ.
//     - IF grant latches we=0, width=010.
//     - *_req_ready is 0 in every non-IDLE state.
//   Priority (both valid in IDLE): LS wins unless streak==STARVE_LIMIT, then IF wins.
//   Streak counter:
//     - +1 on LS grant with IF pending; saturates at STARVE_LIMIT.
//     - Cleared on IF grant and on LS grant with IF not pending.
//   REQ: mem_req_valid=1 with stable latched fields until mem_req_ready; then -> WAIT.
//   WAIT: mem_req_valid=0. On mem_rsp_valid:
//     - Register mem_rdata to owner's rdata; pulse owner's rsp_valid next cycle.
//     - -> IDLE. IDLE may grant in that same pulse cycle.
//     - ls_rdata is 0 for stores.
//   MISAL: ls_rsp_valid=1, ls_rsp_err=1, ls_rdata=0 for one cycle; no memory access; -> IDLE.
//   Latency (zero-wait memory, rsp cycle after handshake):
//     accept t, mem_req_valid t+1, rsp t+2, requester rsp_valid t+3.
//     Back-to-back accepts every 3 cycles.
//   mem_rsp_valid in IDLE/REQ/MISAL: ignored, sets err_spurious (cleared only by reset).
//   rdata outputs hold their last value between pulses; consumers qualify with rsp_valid.
// STRUCTURE
//   Package riscv_mem_pkg:
//     - width localparams (MEM_B/H/W/BU/HU)
//     - arb_state_t enum {IDLE,REQ,WAIT,MISAL}
//     - owner_t enum {OWN_IF,OWN_LS}
//   Sub-module mem_arb_select:
//     - streak counter and grant logic
//     - in: if_valid, ls_valid, grant_en; out: grant_if, grant_ls
//   The FSM and datapath registers stay in the top module.
// TESTING
//   1 IF only, addr 0x100, mem ready immediately, rdata 0x00500093 ->
//     if_req_ready@t, mem_req_valid@t+1, if_rsp_valid/if_rdata=0x00500093@t+3.
//   2 IF+LS valid together, LS load W 0x2000 ->
//     LS granted first; IF granted in the IDLE cycle after LS completes.
//   3 IF held valid, LS valid 6 back-to-back, STARVE_LIMIT=4 ->
//     grant order LS,LS,LS,LS,IF,LS,LS.
//   4 LS store H addr 0x1003 ->
//     ls_rsp_valid=1, ls_rsp_err=1 one cycle after accept; mem_req_valid never asserts.
//   5 LS store W 0x40=0xDEADBEEF, mem_req_ready low 3 cycles ->
//     mem_addr/mem_wdata/mem_we=1 stable throughout; ls_rsp_valid=1, ls_rdata=0 after ack.
//   6 reset asserted in WAIT, then mem_rsp_valid in IDLE ->
//     outputs 0 next cycle, err_spurious=1, no rsp pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_mem_pkg
// Brief   : Shared types and constants for the unified memory port arbiter.
//           Width codes follow the RISC-V load/store funct3 field.
// Revision: 1.0  initial release
// ============================================================================
package riscv_mem_pkg;

  // Access width codes (funct3)
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // Arbiter transaction state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    MISAL = 2'd3
  } arb_state_t;

  // Which requester owns the outstanding transaction
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Halfwords need bit 0 clear, words need bits 1:0 clear; bytes are
  // always aligned. Unlisted codes are treated as aligned.
  function automatic logic is_misaligned(input logic [2:0] width,
                                         input logic [1:0] addr_lo);
    case (width)
      MEM_H, MEM_HU: return addr_lo[0];
      MEM_W:         return (addr_lo != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: mem_port_arbiter_if
// Brief    : Request/response bus of the single unified memory port.
//            master = arbiter side, slave = memory side.
// Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [2:0]        width;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_valid, addr, we, width, wdata,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, we, width, wdata,
    output req_ready, rsp_valid, rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_select.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_select
// Brief   : Grant selection between IF and LS. LS normally wins; a streak
//           counter of LS grants taken while IF waited forces an IF grant
//           once it reaches STARVE_LIMIT.
// Revision: 1.0  initial release
// ============================================================================
module mem_arb_select #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_ls
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_streak;
  logic             w_starved;

  assign w_starved = (r_streak == LIMIT);

  // Pick at most one requester; IF wins when alone or when starved
  always_comb begin
    grant_if = grant_en && if_valid && (!ls_valid || w_starved);
    grant_ls = grant_en && ls_valid && !grant_if;
  end

  // Count LS grants that overtook a waiting IF; saturate at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (grant_if) begin
      r_streak <= '0;
    end else if (grant_ls) begin
      if (!if_valid)
        r_streak <= '0;
      else if (!w_starved)
        r_streak <= r_streak + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares the unified memory port between instruction fetch (IF)
//           and load/store (LS). One transaction outstanding at a time;
//           misaligned LS accesses complete with an error and never reach
//           the memory.
// Revision: 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_we,
  input  logic [2:0]        ls_width,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic              ls_rsp_err,
  output logic [DATA_W-1:0] ls_rdata,
  // memory port
  mem_port_arbiter_if.master mem,
  // status
  output logic              err_spurious
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_width;
  logic [DATA_W-1:0] r_wdata;

  logic              r_if_rsp_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ls_rsp_valid;
  logic              r_ls_rsp_err;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_err_spurious;

  logic              w_grant_en;
  logic              w_grant_if;
  logic              w_grant_ls;
  logic              w_ls_misal;
  logic              w_mem_req_valid;

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_en (w_grant_en),
    .grant_if (w_grant_if),
    .grant_ls (w_grant_ls)
  );

  assign w_ls_misal = is_misaligned(ls_width, ls_addr[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next-state: IDLE -> REQ -> WAIT -> IDLE, or IDLE -> MISAL -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_ls && w_ls_misal)
          w_next = MISAL;
        else if (w_grant_if || w_grant_ls)
          w_next = REQ;
      end
      REQ:     if (mem.req_ready) w_next = WAIT;
      WAIT:    if (mem.rsp_valid) w_next = IDLE;
      MISAL:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs: grants only in IDLE (and not under reset),
  // memory request only in REQ
  always_comb begin
    w_grant_en      = 1'b0;
    w_mem_req_valid = 1'b0;
    case (r_state)
      IDLE:    w_grant_en      = !reset;
      REQ:     w_mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the granted request; fields stay stable until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_width <= MEM_W;
      r_wdata <= '0;
    end else if (w_grant_if) begin
      r_owner <= OWN_IF;
      r_addr  <= if_addr;
      r_we    <= 1'b0;
      r_width <= MEM_W;
      r_wdata <= '0;
    end else if (w_grant_ls) begin
      r_owner <= OWN_LS;
      r_addr  <= ls_addr;
      r_we    <= ls_we;
      r_width <= ls_width;
      r_wdata <= ls_wdata;
    end
  end

  // Response pulses: memory completion routed to owner, or misalign error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rdata     <= '0;
      r_ls_rsp_valid <= 1'b0;
      r_ls_rsp_err   <= 1'b0;
      r_ls_rdata     <= '0;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_ls_rsp_err   <= 1'b0;
      if (r_state == WAIT && mem.rsp_valid) begin
        if (r_owner == OWN_IF) begin
          r_if_rsp_valid <= 1'b1;
          r_if_rdata     <= mem.rdata;
        end else begin
          r_ls_rsp_valid <= 1'b1;
          r_ls_rdata     <= r_we ? '0 : mem.rdata;
        end
      end else if (w_grant_ls && w_ls_misal) begin
        r_ls_rsp_valid <= 1'b1;
        r_ls_rsp_err   <= 1'b1;
        r_ls_rdata     <= '0;
      end
    end
  end

  // Sticky flag for a memory response arriving with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset)
      r_err_spurious <= 1'b0;
    else if (mem.rsp_valid && r_state != WAIT)
      r_err_spurious <= 1'b1;
  end

  assign if_req_ready  = w_grant_if;
  assign ls_req_ready  = w_grant_ls;
  assign if_rsp_valid  = r_if_rsp_valid;
  assign if_rdata      = r_if_rdata;
  assign ls_rsp_valid  = r_ls_rsp_valid;
  assign ls_rsp_err    = r_ls_rsp_err;
  assign ls_rdata      = r_ls_rdata;
  assign err_spurious  = r_err_spurious;

  assign mem.req_valid = w_mem_req_valid;
  assign mem.addr      = r_addr;
  assign mem.we        = r_we;
  assign mem.width     = r_width;
  assign mem.wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter. The bench
//           plays the memory; a cycle table covers single-cycle behaviour,
//           hand sequences cover starvation, back-pressure and reset.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid, ls_rsp_err;
  logic [2:0]  ls_width;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        err_spurious;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rdata     (if_rdata),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_addr      (ls_addr),
    .ls_we        (ls_we),
    .ls_width     (ls_width),
    .ls_wdata     (ls_wdata),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_err   (ls_rsp_err),
    .ls_rdata     (ls_rdata),
    .mem          (mem_if),
    .err_spurious (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One table row per clock cycle. Flags order:
  // {if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid,
  //  ls_rsp_valid, ls_rsp_err, err_spurious}
  typedef struct {
    logic        ifv;
    logic        lsv;
    logic [31:0] lsa;
    logic        lswe;
    logic [2:0]  lsw;
    logic        mrdy;
    logic        mrsp;
    logic [31:0] mrd;
    logic [6:0]  e_flags;
    logic [31:0] e_ifrd;
    logic [31:0] e_lsrd;
    logic [31:0] e_maddr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int   exp_is_if [7] = '{0, 0, 0, 0, 1, 0, 0};
  logic got_if [7];

  initial begin
    int   ngr, nls, ls_rsps, if_rsps;
    logic hs;

    // IF only @0x100 (rows 0-3)
    vecs[0]  = '{1'b1, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        7'b1000000, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b1, 1'b0, 32'h0,        7'b0010000, 32'h0,        32'h0,        32'h100};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b1, 32'h00500093, 7'b0000000, 32'h0,        32'h0,        32'h100};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        7'b0001000, 32'h00500093, 32'h0,        32'h100};
    // IF+LS together, LS load W @0x2000 wins, IF granted on LS completion
    vecs[4]  = '{1'b1, 1'b1, 32'h2000, 1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        7'b0100000, 32'h00500093, 32'h0,        32'h100};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,    1'b0, 3'b010, 1'b1, 1'b0, 32'h0,        7'b0010000, 32'h00500093, 32'h0,        32'h2000};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b1, 32'hCAFEF00D, 7'b0000000, 32'h00500093, 32'h0,        32'h2000};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        7'b1000100, 32'h00500093, 32'hCAFEF00D, 32'h2000};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b1, 1'b0, 32'h0,        7'b0010000, 32'h00500093, 32'hCAFEF00D, 32'h100};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b1, 32'h00000013, 7'b0000000, 32'h00500093, 32'hCAFEF00D, 32'h100};
    vecs[10] = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        7'b0001000, 32'h00000013, 32'hCAFEF00D, 32'h100};
    // Misaligned store H @0x1003: error pulse, no memory request
    vecs[11] = '{1'b0, 1'b1, 32'h1003, 1'b1, 3'b001, 1'b0, 1'b0, 32'h0,        7'b0100000, 32'h00000013, 32'hCAFEF00D, 32'h100};
    vecs[12] = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        7'b0000110, 32'h00000013, 32'h0,        32'h1003};
    vecs[13] = '{1'b0, 1'b0, 32'h0,    1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        7'b0000000, 32'h00000013, 32'h0,        32'h1003};

    reset            = 1'b1;
    if_req_valid     = 1'b0;
    if_addr          = 32'h100;
    ls_req_valid     = 1'b0;
    ls_addr          = 32'h0;
    ls_we            = 1'b0;
    ls_width         = 3'b010;
    ls_wdata         = 32'h0;
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b0;
    mem_if.rdata     = 32'h0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_state",
          {mem_if.req_valid, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
           ls_rsp_err, err_spurious, mem_if.we, mem_if.width, mem_if.addr, if_rdata, ls_rdata},
          {8'h00, 3'b010, 32'h0, 32'h0, 32'h0});
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < NV; i++) begin
      if_req_valid     = vecs[i].ifv;
      ls_req_valid     = vecs[i].lsv;
      ls_addr          = vecs[i].lsa;
      ls_we            = vecs[i].lswe;
      ls_width         = vecs[i].lsw;
      mem_if.req_ready = vecs[i].mrdy;
      mem_if.rsp_valid = vecs[i].mrsp;
      mem_if.rdata     = vecs[i].mrd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {if_req_ready, ls_req_ready, mem_if.req_valid, if_rsp_valid, ls_rsp_valid,
             ls_rsp_err, err_spurious, if_rdata, ls_rdata, mem_if.addr},
            {vecs[i].e_flags, vecs[i].e_ifrd, vecs[i].e_lsrd, vecs[i].e_maddr});
      @(posedge clk); #1;
    end

    // Starvation guard: IF held, six LS loads back-to-back
    ngr = 0; nls = 0; ls_rsps = 0; if_rsps = 0; hs = 1'b0;
    for (int k = 0; k < 7; k++) got_if[k] = 1'b0;
    if_req_valid = 1'b1;
    ls_addr      = 32'h300;
    ls_we        = 1'b0;
    ls_width     = 3'b010;
    for (int cyc = 0; cyc < 200 && ngr < 7; cyc++) begin
      ls_req_valid     = (nls < 6);
      mem_if.req_ready = 1'b1;
      mem_if.rsp_valid = hs;
      mem_if.rdata     = 32'h1000 + cyc;
      @(negedge clk);
      hs = mem_if.req_valid && mem_if.req_ready;
      if (ls_rsp_valid) ls_rsps++;
      if (if_rsp_valid) if_rsps++;
      if (if_req_ready && ngr < 7) begin got_if[ngr] = 1'b1; ngr++; end
      if (ls_req_ready && ngr < 7) begin got_if[ngr] = 1'b0; ngr++; nls++; end
      @(posedge clk); #1;
    end
    check("starve_grant_count", ngr, 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("starve_order%0d", k), got_if[k], exp_is_if[k]);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      mem_if.req_ready = 1'b1;
      mem_if.rsp_valid = hs;
      mem_if.rdata     = 32'h2000 + cyc;
      @(negedge clk);
      hs = mem_if.req_valid && mem_if.req_ready;
      if (ls_rsp_valid) ls_rsps++;
      if (if_rsp_valid) if_rsps++;
      @(posedge clk); #1;
    end
    check("starve_ls_rsps", ls_rsps, 6);
    check("starve_if_rsps", if_rsps, 1);

    // Store W with back-pressure: fields stay stable, store returns 0
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b0;
    ls_req_valid     = 1'b1;
    ls_addr          = 32'h40;
    ls_we            = 1'b1;
    ls_width         = 3'b010;
    ls_wdata         = 32'hDEADBEEF;
    @(negedge clk);
    check("st_accept", ls_req_ready, 1'b1);
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    ls_addr      = 32'h0;
    ls_we        = 1'b0;
    ls_wdata     = 32'h0;
    for (int c = 0; c < 4; c++) begin
      mem_if.req_ready = (c == 3);
      @(negedge clk);
      check($sformatf("st_hold%0d", c),
            {mem_if.req_valid, mem_if.we, mem_if.width, mem_if.addr, mem_if.wdata},
            {1'b1, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF});
      @(posedge clk); #1;
    end
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b1;
    mem_if.rdata     = 32'h55555555;
    @(negedge clk);
    check("st_wait", {mem_if.req_valid, ls_rsp_valid}, 2'b00);
    @(posedge clk); #1;
    mem_if.rsp_valid = 1'b0;
    @(negedge clk);
    check("st_rsp", {ls_rsp_valid, ls_rsp_err, ls_rdata}, {1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    @(negedge clk);
    check("st_rsp_end", ls_rsp_valid, 1'b0);
    @(posedge clk); #1;

    // Reset in WAIT, then a stray response in IDLE
    ls_req_valid = 1'b1;
    ls_addr      = 32'h80;
    ls_we        = 1'b0;
    ls_width     = 3'b010;
    @(negedge clk);
    check("rst_accept", ls_req_ready, 1'b1);
    @(posedge clk); #1;
    ls_req_valid     = 1'b0;
    mem_if.req_ready = 1'b1;
    @(posedge clk); #1;
    mem_if.req_ready = 1'b0;
    reset            = 1'b1;
    @(posedge clk); #1;
    reset            = 1'b0;
    mem_if.rsp_valid = 1'b1;
    mem_if.rdata     = 32'hAAAA5555;
    @(negedge clk);
    check("rst_outputs",
          {mem_if.req_valid, ls_rsp_valid, if_rsp_valid, ls_req_ready, if_req_ready,
           err_spurious, mem_if.we, mem_if.width, mem_if.addr, ls_rdata, if_rdata},
          {7'b0000000, 3'b010, 32'h0, 32'h0, 32'h0});
    @(posedge clk); #1;
    mem_if.rsp_valid = 1'b0;
    @(negedge clk);
    check("rst_spurious", {err_spurious, ls_rsp_valid, if_rsp_valid, ls_rdata},
          {3'b100, 32'h0});
    @(posedge clk); #1;
    @(negedge clk);
    check("spurious_sticky", err_spurious, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("spurious_clear", err_spurious, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
